// File: rtl/axi_lite_times_table_slave_if.sv
// AXI4-Lite bus bundle for the times-table responder.
// The master modport belongs to whoever issues transactions. The slave modport
// belongs to the responder.
//
// Handshake rule, used on every channel (AW, W, B, AR, R):
// a transfer happens on a rising clk edge where valid && ready are both high.
// Once the source raises valid, it holds the payload stable until that edge.
interface axi_lite_times_table_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_times_table_slave.sv
// AXI4-Lite responder holding a 64 x 32-bit times table.
// Entry {b,a} holds a*b. After reset the table fills itself, one entry per
// cycle. After that the block serves single-beat reads and byte-strobed writes,
// with one transaction outstanding at a time.
// Any address bit at position 8 or above makes the access out of range. An
// out-of-range access gets SLVERR and does not touch the memory.
module axi_lite_times_table_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INIT_TABLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_lite_times_table_slave_if.slave s_axi,
  output logic                        init_done,
  output logic [1:0]                  fsm_state
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    RDATA = 2'd2,
    WRESP = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                state;
  logic [5:0]            fill_idx;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  bvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [1:0]            bresp_q;

  logic [DATA_WIDTH-1:0] mem [64];

  logic [5:0]            rd_idx;
  logic [5:0]            wr_idx;
  logic                  rd_oor;
  logic                  wr_oor;
  logic                  ar_hs;
  logic                  wr_accept;
  logic [5:0]            fill_prod;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  unused_addr_bits;

  // Byte offset bits never select anything.
  assign unused_addr_bits = ^{s_axi.araddr[1:0], s_axi.awaddr[1:0]};

  assign rd_idx = s_axi.araddr[7:2];
  assign wr_idx = s_axi.awaddr[7:2];
  assign rd_oor = |s_axi.araddr[ADDR_WIDTH-1:8];
  assign wr_oor = |s_axi.awaddr[ADDR_WIDTH-1:8];

  // arready_q is high only in IDLE, so this handshake can only fire there.
  assign ar_hs = arready_q && s_axi.arvalid;

  // AW and W are accepted together, and only when no read is competing.
  // This keeps the two write channels locked to the same cycle.
  assign wr_accept = (state == IDLE) && s_axi.awvalid && s_axi.wvalid && !s_axi.arvalid;

  // The fill value for entry i is a*b, where a = i[2:0] and b = i[5:3].
  assign fill_prod = {3'b000, fill_idx[2:0]} * {3'b000, fill_idx[5:3]};
  assign fill_word = (INIT_TABLE != 0) ? {{(DATA_WIDTH-6){1'b0}}, fill_prod} : '0;

  assign s_axi.arready = arready_q;
  assign s_axi.awready = wr_accept;
  assign s_axi.wready  = wr_accept;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign fsm_state     = state;

  // Table storage. This block has no reset, because the INIT state refills
  // every entry after each reset.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[fill_idx] <= fill_word;
    end else if (wr_accept && !wr_oor) begin
      for (int k = 0; k < DATA_WIDTH/8; k++) begin
        if (s_axi.wstrb[k]) begin
          mem[wr_idx][8*k +: 8] <= s_axi.wdata[8*k +: 8];
        end
      end
    end
  end

  // Control FSM: table fill, then arbitration, read response and write response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      fill_idx  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          fill_idx <= fill_idx + 6'd1;
          if (fill_idx == 6'd63) begin
            state     <= IDLE;
            init_done <= 1'b1;
            arready_q <= 1'b1;
          end
        end
        IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_oor ? '0 : mem[rd_idx];
            rresp_q   <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            state     <= RDATA;
          end else if (wr_accept) begin
            arready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_oor ? RESP_SLVERR : RESP_OKAY;
            state     <= WRESP;
          end
        end
        RDATA: begin
          if (s_axi.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state     <= IDLE;
          end
        end
        WRESP: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_times_table_slave.sv
// Directed and randomized bench for the times-table AXI4-Lite responder.
// A reference array, model_mem, holds a*b plus every accepted write.
// Expected read data flows through exp_q.
module tb_axi_lite_times_table_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic [1:0] fsm_state;

  axi_lite_times_table_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axi ();

  axi_lite_times_table_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .INIT_TABLE(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (s_axi),
    .init_done (init_done),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] model_mem [64];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] addr);
    return addr[31:8] != 24'h0;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'((i % 8) * (i / 8));
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (!is_oor(addr)) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) model_mem[addr[7:2]][8*k +: 8] = data[8*k +: 8];
      end
    end
  endtask

  // Read driver. It is entered and left at posedge+1. The data beat is then
  // held for 'hold' cycles with rready low before it is retired.
  task automatic axi_read(input logic [31:0] addr, input int hold, input string tag);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int          t;
    exp_d = is_oor(addr) ? 32'h0 : model_mem[addr[7:2]];
    exp_r = is_oor(addr) ? 2'b10 : 2'b00;
    exp_q.push_back(exp_d);
    s_axi.araddr  = addr;
    s_axi.arvalid = 1'b1;
    s_axi.rready  = 1'b0;
    #1;
    t = 0;
    while (!s_axi.arready && t < 200) begin
      @(posedge clk); #2; t++;
    end
    check({tag, " arready"}, 32'(s_axi.arready), 32'd1);
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    check({tag, " rvalid"}, 32'(s_axi.rvalid), 32'd1);
    check({tag, " rdata"}, s_axi.rdata, exp_q.pop_front());
    check({tag, " rresp"}, 32'(s_axi.rresp), 32'(exp_r));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " rvalid held"}, 32'(s_axi.rvalid), 32'd1);
      check({tag, " rdata held"}, s_axi.rdata, exp_d);
    end
    s_axi.rready = 1'b1;
    @(posedge clk); #1;
    s_axi.rready = 1'b0;
    check({tag, " rvalid retired"}, 32'(s_axi.rvalid), 32'd0);
  endtask

  // Write driver. It is entered and left at posedge+1.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    logic [1:0] exp_b;
    int         t;
    exp_b = is_oor(addr) ? 2'b10 : 2'b00;
    s_axi.awaddr  = addr;
    s_axi.wdata   = data;
    s_axi.wstrb   = strb;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    s_axi.bready  = 1'b0;
    #1;
    t = 0;
    while (!(s_axi.awready && s_axi.wready) && t < 200) begin
      @(posedge clk); #2; t++;
    end
    check({tag, " awready"}, 32'(s_axi.awready && s_axi.wready), 32'd1);
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    model_write(addr, data, strb);
    check({tag, " bvalid"}, 32'(s_axi.bvalid), 32'd1);
    check({tag, " bresp"}, 32'(s_axi.bresp), 32'(exp_b));
    s_axi.bready = 1'b1;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
    check({tag, " bvalid retired"}, 32'(s_axi.bvalid), 32'd0);
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 200) begin
      @(posedge clk); #1; cycles++;
    end
  endtask

  initial begin
    int          cycles;
    int          bad;
    int          t;
    logic [31:0] addr;
    logic [31:0] data;

    rst = 1'b0;
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
    s_axi.wvalid = 1'b0; s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;
    model_init();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst arready", 32'(s_axi.arready), 32'd0);
    check("rst awready", 32'(s_axi.awready), 32'd0);
    check("rst rvalid", 32'(s_axi.rvalid), 32'd0);
    check("rst bvalid", 32'(s_axi.bvalid), 32'd0);
    check("rst rdata", s_axi.rdata, 32'h0);
    check("rst resp", 32'({s_axi.rresp, s_axi.bresp}), 32'd0);
    check("rst init_done", 32'(init_done), 32'd0);
    check("rst state", 32'(fsm_state), 32'd0);

    // Test 1: init takes 64 cycles, and arvalid pulsed during INIT is ignored.
    rst = 1'b1;
    cycles = 0;
    bad = 0;
    while (!init_done && cycles < 200) begin
      @(posedge clk); #1; cycles++;
      if ((s_axi.arready || s_axi.awready) && !init_done) bad++;
      if (s_axi.rvalid) bad++;
      s_axi.arvalid = (cycles >= 10 && cycles < 13);
    end
    s_axi.arvalid = 1'b0;
    check("init cycles", 32'(cycles), 32'd64);
    check("init no ready/rvalid", 32'(bad), 32'd0);
    check("idle arready", 32'(s_axi.arready), 32'd1);
    check("idle rvalid", 32'(s_axi.rvalid), 32'd0);

    // Test 2: basic reads.
    axi_read(32'h0000_00AC, 0, "rd 0xAC");
    axi_read(32'h0000_00FC, 0, "rd 0xFC");
    axi_read(32'h0000_0000, 0, "rd 0x00");
    // Test 3: backpressure on R.
    axi_read(32'h0000_00AC, 5, "rd 0xAC hold");

    // Test 4: strobed write, then read back.
    axi_write(32'h0000_0008, 32'hDEAD_BEEF, 4'b0011, "wr 0x08");
    axi_read(32'h0000_0008, 0, "rd 0x08");
    axi_write(32'h0000_0008, 32'h1234_5678, 4'b0000, "wr strb0");
    axi_read(32'h0000_0008, 1, "rd 0x08 strb0");

    // Test 5: out-of-range accesses.
    axi_read(32'h0000_0100, 0, "rd oor");
    axi_write(32'h0000_0100, 32'hFFFF_FFFF, 4'b1111, "wr oor");
    axi_read(32'h0000_0000, 0, "rd 0x00 after oor");

    // Randomized mix of reads and writes.
    for (int n = 0; n < 40; n++) begin
      addr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) addr = addr | (32'($urandom_range(1, 255)) << 8);
      if ($urandom_range(0, 1) == 0) begin
        axi_read(addr, $urandom_range(0, 3), "rand rd");
      end else begin
        data = $urandom;
        axi_write(addr, data, 4'($urandom_range(0, 15)), "rand wr");
      end
    end

    // Test 6: a simultaneous read and write are served read first.
    s_axi.araddr = 32'h0000_00FC; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
    s_axi.awaddr = 32'h0000_0008; s_axi.wdata = 32'h1234_5678; s_axi.wstrb = 4'hF;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
    #1;
    check("prio arready", 32'(s_axi.arready), 32'd1);
    check("prio awready low", 32'(s_axi.awready), 32'd0);
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    check("prio rvalid", 32'(s_axi.rvalid), 32'd1);
    check("prio rdata", s_axi.rdata, model_mem[63]);
    check("prio awready in rdata", 32'(s_axi.awready), 32'd0);
    s_axi.rready = 1'b1;
    @(posedge clk); #1;
    s_axi.rready = 1'b0;
    check("prio write accepted", 32'(s_axi.awready && s_axi.wready), 32'd1);
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    model_write(32'h0000_0008, 32'h1234_5678, 4'hF);
    check("prio bvalid", 32'(s_axi.bvalid), 32'd1);
    check("prio bresp", 32'(s_axi.bresp), 32'd0);
    s_axi.bready = 1'b1;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
    axi_read(32'h0000_0008, 0, "rd after prio wr");

    // Asserting reset while rvalid is high aborts the read and refills the table.
    s_axi.araddr = 32'h0000_0008; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
    #1;
    t = 0;
    while (!s_axi.arready && t < 200) begin
      @(posedge clk); #2; t++;
    end
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    check("pre-reset rvalid", 32'(s_axi.rvalid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async rst rvalid", 32'(s_axi.rvalid), 32'd0);
    check("async rst init_done", 32'(init_done), 32'd0);
    check("async rst arready", 32'(s_axi.arready), 32'd0);
    check("async rst state", 32'(fsm_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_init();
    wait_init(cycles);
    check("reinit cycles", 32'(cycles), 32'd64);
    axi_read(32'h0000_0008, 0, "rd 0x08 after reinit");
    axi_read(32'h0000_00AC, 0, "rd 0xAC after reinit");

    check("exp_q drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
